// File: rtl/exmem_latch_gen_if.sv
// exmem_latch_gen_if
// Bundles the stage-control, memory-completion, payload and status signals of
// the EX/MEM pipeline latch.
//
// Signals (driven by master, read by slave unless noted):
//   en_i        stage advance enable (ihit)
//   flush_i     flush request, effective only together with en_i
//   stall_i     hazard stall
//   dhit_i      data memory completion
//   in_valid    incoming instruction valid
//   in_payload  incoming payload, DATA_W bits
//   in_req      incoming memory request vector, REQ_W bits
//   out_valid   registered valid                     (slave -> master)
//   out_payload registered payload                   (slave -> master)
//   out_req     registered request, cleared when done (slave -> master)
//   busy_o      request outstanding                  (slave -> master)
//   done_o      one-cycle completion pulse           (slave -> master)
//   wait_cnt_o  saturating wait-cycle count          (slave -> master)
interface exmem_latch_gen_if #(
    parameter int DATA_W = 160,
    parameter int REQ_W  = 2,
    parameter int CNT_W  = 8
);
    logic              en_i;
    logic              flush_i;
    logic              stall_i;
    logic              dhit_i;
    logic              in_valid;
    logic [DATA_W-1:0] in_payload;
    logic [REQ_W-1:0]  in_req;
    logic              out_valid;
    logic [DATA_W-1:0] out_payload;
    logic [REQ_W-1:0]  out_req;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  wait_cnt_o;

    modport master (
        output en_i, flush_i, stall_i, dhit_i, in_valid, in_payload, in_req,
        input  out_valid, out_payload, out_req, busy_o, done_o, wait_cnt_o
    );

    modport slave (
        input  en_i, flush_i, stall_i, dhit_i, in_valid, in_payload, in_req,
        output out_valid, out_payload, out_req, busy_o, done_o, wait_cnt_o
    );
endinterface

// File: rtl/exmem_latch_gen.sv
// exmem_latch_gen
// EX/MEM pipeline latch. Registers payload, valid and a memory request vector,
// tracks the outstanding request and freezes the stage until dhit_i arrives.
// Supports flush (abort), hold/bubble stall modes and a saturating wait counter.
//
// Ports:
//   CLK   rising-edge clock
//   nRST  synchronous active-low reset
//   bus   exmem_latch_gen_if.slave (controls, payload in/out, status)
//
// state | meaning
// IDLE  | no request outstanding, out_req == 0
// PEND  | out_req != 0, waiting for dhit_i
module exmem_latch_gen #(
    parameter int DATA_W     = 160,
    parameter int REQ_W      = 2,
    parameter int CNT_W      = 8,
    parameter int STALL_MODE = 0
) (
    input  logic CLK,
    input  logic nRST,
    exmem_latch_gen_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic [REQ_W-1:0]  req_q, req_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              pend;
    logic              adv;
    logic              flush_eff;
    logic [REQ_W-1:0]  load_req;
    logic              load_pend;

    assign pend      = (state_q == PEND);
    assign flush_eff = bus.flush_i & bus.en_i;
    // While a request is outstanding the stage may only move on the completing cycle.
    assign adv       = bus.en_i & ~bus.stall_i & (~pend | bus.dhit_i);
    // An invalid instruction must never start a memory request.
    assign load_req  = bus.in_valid ? bus.in_req : '0;
    assign load_pend = |load_req;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_eff) begin
            state_d = IDLE;
        end else if (adv) begin
            state_d = load_pend ? PEND : IDLE;
        end else if (pend && bus.dhit_i) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        req_d     = req_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        if (flush_eff) begin
            // Aborted requests do not report completion.
            valid_d   = 1'b0;
            payload_d = '0;
            req_d     = '0;
            cnt_d     = '0;
        end else if (adv) begin
            valid_d   = bus.in_valid;
            payload_d = bus.in_payload;
            req_d     = load_req;
            cnt_d     = '0;
            // adv out of PEND implies dhit_i, so the old request completes here.
            done_d    = pend;
        end else if (pend && bus.dhit_i) begin
            req_d  = '0;
            done_d = 1'b1;
        end else if (pend) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (bus.en_i && bus.stall_i && (STALL_MODE == 1)) begin
            // Bubble: kill the instruction but keep the payload bits.
            valid_d = 1'b0;
            req_d   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            req_q     <= '0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            req_q     <= req_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_payload = payload_q;
    assign bus.out_req     = req_q;
    assign bus.busy_o      = pend;
    assign bus.done_o      = done_q;
    assign bus.wait_cnt_o  = cnt_q;
endmodule

// File: tb/tb_exmem_latch_gen.sv
module tb_exmem_latch_gen;
    localparam int DW = 32;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic          en, flush, stall, dhit, inv;
    logic [DW-1:0] inp;
    logic [1:0]    inr;

    exmem_latch_gen_if #(.DATA_W(DW), .REQ_W(2), .CNT_W(8)) if0 ();
    exmem_latch_gen_if #(.DATA_W(DW), .REQ_W(2), .CNT_W(8)) if1 ();
    exmem_latch_gen_if #(.DATA_W(DW), .REQ_W(2), .CNT_W(3)) if2 ();

    assign if0.en_i = en;    assign if1.en_i = en;    assign if2.en_i = en;
    assign if0.flush_i = flush; assign if1.flush_i = flush; assign if2.flush_i = flush;
    assign if0.stall_i = stall; assign if1.stall_i = stall; assign if2.stall_i = stall;
    assign if0.dhit_i = dhit;  assign if1.dhit_i = dhit;  assign if2.dhit_i = dhit;
    assign if0.in_valid = inv; assign if1.in_valid = inv; assign if2.in_valid = inv;
    assign if0.in_payload = inp; assign if1.in_payload = inp; assign if2.in_payload = inp;
    assign if0.in_req = inr;   assign if1.in_req = inr;   assign if2.in_req = inr;

    exmem_latch_gen #(.DATA_W(DW), .REQ_W(2), .CNT_W(8), .STALL_MODE(0))
        dut0 (.CLK(CLK), .nRST(nRST), .bus(if0.slave));
    exmem_latch_gen #(.DATA_W(DW), .REQ_W(2), .CNT_W(8), .STALL_MODE(1))
        dut1 (.CLK(CLK), .nRST(nRST), .bus(if1.slave));
    exmem_latch_gen #(.DATA_W(DW), .REQ_W(2), .CNT_W(3), .STALL_MODE(0))
        dut2 (.CLK(CLK), .nRST(nRST), .bus(if2.slave));

    typedef struct {
        logic en, fl, st, dh, v;
        logic [31:0] p;
        logic [1:0]  r;
        logic ev;
        logic [31:0] ep;
        logic [1:0]  er;
        logic eb, ed;
        logic [7:0]  ec;
    } vec_t;

    typedef struct {
        int          which;
        string       tag;
        logic        ev;
        logic [31:0] ep;
        logic [1:0]  er;
        logic        eb, ed;
        logic [7:0]  ec;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   tests = 0;
    int   failed = 0;

    function automatic vec_t mk(logic en_, logic fl, logic st, logic dh, logic v,
                                logic [31:0] p, logic [1:0] r, logic ev,
                                logic [31:0] ep, logic [1:0] er, logic eb,
                                logic ed, logic [7:0] ec);
        vec_t x;
        x.en = en_; x.fl = fl; x.st = st; x.dh = dh; x.v = v; x.p = p; x.r = r;
        x.ev = ev; x.ep = ep; x.er = er; x.eb = eb; x.ed = ed; x.ec = ec;
        return x;
    endfunction

    task automatic drive(logic en_, logic fl, logic st, logic dh, logic v,
                         logic [31:0] p, logic [1:0] r);
        en = en_; flush = fl; stall = st; dhit = dh; inv = v; inp = p; inr = r;
    endtask

    task automatic expect_out(int which, string tag, logic ev, logic [31:0] ep,
                              logic [1:0] er, logic eb, logic ed, logic [7:0] ec);
        exp_t e;
        e.which = which; e.tag = tag; e.ev = ev; e.ep = ep; e.er = er;
        e.eb = eb; e.ed = ed; e.ec = ec;
        exp_q.push_back(e);
    endtask

    task automatic cmp(string tag, string field, int which, logic [31:0] act,
                       logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s dut%0d %s: got %0h expected %0h", tag, which, field,
                     act, exp);
        end
    endtask

    task automatic check_one(exp_t e);
        logic        av, ab, ad;
        logic [31:0] ap;
        logic [1:0]  ar;
        logic [7:0]  ac;
        case (e.which)
            0: begin
                av = if0.out_valid; ap = if0.out_payload; ar = if0.out_req;
                ab = if0.busy_o; ad = if0.done_o; ac = if0.wait_cnt_o;
            end
            1: begin
                av = if1.out_valid; ap = if1.out_payload; ar = if1.out_req;
                ab = if1.busy_o; ad = if1.done_o; ac = if1.wait_cnt_o;
            end
            default: begin
                av = if2.out_valid; ap = if2.out_payload; ar = if2.out_req;
                ab = if2.busy_o; ad = if2.done_o; ac = {5'b0, if2.wait_cnt_o};
            end
        endcase
        cmp(e.tag, "valid",   e.which, {31'b0, av}, {31'b0, e.ev});
        cmp(e.tag, "payload", e.which, ap, e.ep);
        cmp(e.tag, "req",     e.which, {30'b0, ar}, {30'b0, e.er});
        cmp(e.tag, "busy",    e.which, {31'b0, ab}, {31'b0, e.eb});
        cmp(e.tag, "done",    e.which, {31'b0, ad}, {31'b0, e.ed});
        cmp(e.tag, "wait_cnt", e.which, {24'b0, ac}, {24'b0, e.ec});
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        while (exp_q.size() > 0) check_one(exp_q.pop_front());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Main table for dut0 (STALL_MODE=0, CNT_W=8), starting right after reset.
        //             en fl st dh v  payload       r      ev ep            er     eb ed ec
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h1234, 2'b00, 1, 32'h1234, 2'b00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'hAAAA, 2'b01, 1, 32'hAAAA, 2'b01, 1, 0, 0));
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(1, 0, 0, 0, 1, 32'hBBBB, 2'b00, 1, 32'hAAAA, 2'b01, 1, 0, 8'(k)));
        tbl.push_back(mk(1, 0, 0, 1, 1, 32'hBBBB, 2'b00, 1, 32'hBBBB, 2'b00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0000, 2'b00, 1, 32'hBBBB, 2'b00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'hC0C0, 2'b10, 1, 32'hC0C0, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 32'h7777, 2'b00, 1, 32'hC0C0, 2'b10, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'h7777, 2'b00, 1, 32'hC0C0, 2'b00, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 32'h7777, 2'b00, 1, 32'hC0C0, 2'b00, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'h7777, 2'b01, 1, 32'hC0C0, 2'b00, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'hDDDD, 2'b10, 1, 32'hDDDD, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'h4444, 2'b00, 1, 32'hDDDD, 2'b10, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1, 1, 32'h4444, 2'b01, 0, 32'h0000, 2'b00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'hEEEE, 2'b01, 1, 32'hEEEE, 2'b01, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 32'hFFFF, 2'b00, 1, 32'hEEEE, 2'b01, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 1, 1, 32'hFFFF, 2'b00, 1, 32'hEEEE, 2'b00, 0, 1, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1, 32'hFFFF, 2'b00, 1, 32'hEEEE, 2'b00, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'hFFFF, 2'b11, 0, 32'hFFFF, 2'b00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h1111, 2'b01, 1, 32'h1111, 2'b01, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 32'h2222, 2'b10, 1, 32'h2222, 2'b10, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 32'h3333, 2'b00, 1, 32'h3333, 2'b00, 0, 1, 0));

        // Reset with live inputs: everything must read zero.
        nRST = 1'b0;
        drive(1, 0, 0, 0, 1, 32'hFFFF_FFFF, 2'b01);
        for (int c = 0; c < 2; c++) begin
            for (int d = 0; d < 3; d++) expect_out(d, "reset", 0, 0, 0, 0, 0, 0);
            tick();
        end
        nRST = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].fl, tbl[i].st, tbl[i].dh, tbl[i].v, tbl[i].p, tbl[i].r);
            expect_out(0, $sformatf("row%0d", i), tbl[i].ev, tbl[i].ep, tbl[i].er,
                       tbl[i].eb, tbl[i].ed, tbl[i].ec);
            tick();
        end

        // Stall modes: hold (dut0) versus bubble (dut1) in IDLE.
        nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int d = 0; d < 3; d++) expect_out(d, "reset2", 0, 0, 0, 0, 0, 0);
        tick();
        nRST = 1'b1;
        drive(1, 0, 0, 0, 1, 32'hC0C0, 2'b00);
        expect_out(0, "load_c", 1, 32'hC0C0, 0, 0, 0, 0);
        expect_out(1, "load_c", 1, 32'hC0C0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 1, 0, 1, 32'h9999, 2'b01);
        expect_out(0, "stall_hold", 1, 32'hC0C0, 0, 0, 0, 0);
        expect_out(1, "stall_bubble", 0, 32'hC0C0, 0, 0, 0, 0);
        tick();
        // Bubble mode must still keep an outstanding request under stall.
        drive(1, 0, 0, 0, 1, 32'h5555, 2'b01);
        for (int d = 0; d < 3; d++) expect_out(d, "load_req", 1, 32'h5555, 2'b01, 1, 0, 0);
        tick();
        drive(1, 0, 1, 0, 1, 32'h6666, 2'b00);
        expect_out(0, "pend_stall", 1, 32'h5555, 2'b01, 1, 0, 1);
        expect_out(1, "pend_stall", 1, 32'h5555, 2'b01, 1, 0, 1);
        expect_out(2, "pend_stall", 1, 32'h5555, 2'b01, 1, 0, 1);
        tick();

        // Saturation: dut2 counter is 3 bits, dut0 keeps counting.
        for (int k = 1; k <= 10; k++) begin
            drive(1, 0, 0, 0, 1, 32'h6666, 2'b00);
            expect_out(2, $sformatf("sat%0d", k), 1, 32'h5555, 2'b01, 1, 0,
                       8'((1 + k > 7) ? 7 : 1 + k));
            expect_out(0, $sformatf("cnt%0d", k), 1, 32'h5555, 2'b01, 1, 0, 8'(1 + k));
            tick();
        end

        // Reset mid-request with dhit high: no completion pulse.
        nRST = 1'b0;
        drive(1, 0, 0, 1, 1, 32'h6666, 2'b00);
        for (int d = 0; d < 3; d++) expect_out(d, "rst_mid", 0, 0, 0, 0, 0, 0);
        tick();
        nRST = 1'b1;
        drive(0, 0, 0, 1, 0, 32'h0, 2'b00);
        expect_out(2, "idle_dhit", 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
